// File: rtl/rvcore_pipe_pkg.sv
// rtl/rvcore_pipe_pkg.sv - MEM->WB payload layout and occupancy constants for pipe_stage_reg
package rvcore_pipe_pkg;

  localparam int unsigned REG_WDATA_W = 32;
  localparam int unsigned REG_WADDR_W = 5;
  localparam int unsigned REG_WE_W    = 1;
  localparam int unsigned CSR_WDATA_W = 32;
  localparam int unsigned CSR_WADDR_W = 12;
  localparam int unsigned CSR_WE_W    = 1;

  // Fields packed LSB-first in the order listed above
  localparam int unsigned REG_WDATA_LSB = 0;
  localparam int unsigned REG_WADDR_LSB = REG_WDATA_LSB + REG_WDATA_W;
  localparam int unsigned REG_WE_LSB    = REG_WADDR_LSB + REG_WADDR_W;
  localparam int unsigned CSR_WDATA_LSB = REG_WE_LSB + REG_WE_W;
  localparam int unsigned CSR_WADDR_LSB = CSR_WDATA_LSB + CSR_WDATA_W;
  localparam int unsigned CSR_WE_LSB    = CSR_WADDR_LSB + CSR_WADDR_W;

  localparam int unsigned MEMWB_DATA_W  = CSR_WE_LSB + CSR_WE_W;

  localparam int unsigned OCC_W = 2;
  localparam logic [OCC_W-1:0] OCC_EMPTY = 2'd0;
  localparam logic [OCC_W-1:0] OCC_ONE   = 2'd1;
  localparam logic [OCC_W-1:0] OCC_FULL  = 2'd2;

  function automatic logic [MEMWB_DATA_W-1:0] pack_memwb(
    input logic [REG_WDATA_W-1:0] reg_wdata,
    input logic [REG_WADDR_W-1:0] reg_waddr,
    input logic                   reg_we,
    input logic [CSR_WDATA_W-1:0] csr_wdata,
    input logic [CSR_WADDR_W-1:0] csr_waddr,
    input logic                   csr_we
  );
    return {csr_we, csr_waddr, csr_wdata, reg_we, reg_waddr, reg_wdata};
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - single payload register with clear-to-RST_VAL, load and hold
module pipe_slot #(
  parameter int unsigned       DATA_W  = 8,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              load,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= RST_VAL;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline stage register; PIPE_SKID_EN adds a 2-entry skid
module pipe_stage_reg
  import rvcore_pipe_pkg::*;
#(
  parameter int unsigned       DATA_W  = MEMWB_DATA_W,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              fc_stall_i,
  input  logic              fc_flush_i,
  output logic [OCC_W-1:0]  occ_o
);

  logic [OCC_W-1:0]  count;
  logic [OCC_W-1:0]  count_next;
  logic              accept;
  logic              pop;
  logic              clr;
  logic              main_load;
  logic [DATA_W-1:0] main_d;
  logic [DATA_W-1:0] main_q;

  // Stall outranks flush, so a flush raised under stall has no effect
  assign clr         = rst | (fc_flush_i & ~fc_stall_i);
  assign accept      = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;
  assign out_valid_o = (count != OCC_EMPTY) & ~fc_stall_i;
  assign out_data_o  = main_q;
  assign occ_o       = count;

`ifdef PIPE_SKID_EN
  logic              skid_load;
  logic [DATA_W-1:0] skid_q;

  assign in_ready_o = (count != OCC_FULL) & ~fc_stall_i;

  always_comb begin
    count_next = count;
    main_load  = 1'b0;
    main_d     = in_data_i;
    skid_load  = 1'b0;
    case (count)
      OCC_EMPTY: begin
        if (accept) begin
          main_load  = 1'b1;
          count_next = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (accept && pop) begin
          main_load = 1'b1;
        end else if (accept) begin
          skid_load  = 1'b1;
          count_next = OCC_FULL;
        end else if (pop) begin
          count_next = OCC_EMPTY;
        end
      end
      OCC_FULL: begin
        if (pop) begin
          main_load  = 1'b1;
          main_d     = skid_q;
          count_next = OCC_ONE;
        end
      end
      default: count_next = OCC_EMPTY;
    endcase
  end

  pipe_slot #(
    .DATA_W (DATA_W),
    .RST_VAL(RST_VAL)
  ) u_skid (
    .clk (clk),
    .clr (clr),
    .load(skid_load),
    .d   (in_data_i),
    .q   (skid_q)
  );
`else
  // Single slot: full throughput requires ready to see the downstream pop
  assign in_ready_o = ((count == OCC_EMPTY) | out_ready_i) & ~fc_stall_i;

  always_comb begin
    count_next = count;
    main_load  = accept;
    main_d     = in_data_i;
    if (accept) begin
      count_next = OCC_ONE;
    end else if (pop) begin
      count_next = OCC_EMPTY;
    end
  end
`endif

  pipe_slot #(
    .DATA_W (DATA_W),
    .RST_VAL(RST_VAL)
  ) u_main (
    .clk (clk),
    .clr (clr),
    .load(main_load),
    .d   (main_d),
    .q   (main_q)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= OCC_EMPTY;
    end else if (!fc_stall_i) begin
      count <= count_next;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - self-checking bench for pipe_stage_reg with a queue scoreboard
module tb_pipe_stage_reg;

  localparam int DW = 83;
`ifdef PIPE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic          clk;
  logic          rst;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [DW-1:0] in_data_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [DW-1:0] out_data_o;
  logic          fc_stall_i;
  logic          fc_flush_i;
  logic [1:0]    occ_o;

  int checks   = 0;
  int failures = 0;
  logic [DW-1:0] sb[$];

  pipe_stage_reg dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .in_data_i  (in_data_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_data_o (out_data_o),
    .fc_stall_i (fc_stall_i),
    .fc_flush_i (fc_flush_i),
    .occ_o      (occ_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: handshakes are evaluated mid-cycle, where inputs and outputs are settled
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else if (fc_flush_i && !fc_stall_i) begin
      sb.delete();
    end else begin
      if (out_valid_o && out_ready_i) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected_output got=%0h exp=none", out_data_o);
        end else if (out_data_o !== sb[0]) begin
          failures++;
          $display("FAIL sb_data got=%0h exp=%0h", out_data_o, sb[0]);
          void'(sb.pop_front());
        end else begin
          void'(sb.pop_front());
        end
      end
      if (in_valid_i && in_ready_o) sb.push_back(in_data_i);
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid_i = 1'b1; in_data_i = DW'(32'hDEAD);
    cycle();
    cycle();
    checks++; if (out_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", out_valid_o); end
    checks++; if (out_data_o !== '0) begin failures++; $display("FAIL reset_data got=%0h exp=0", out_data_o); end
    checks++; if (occ_o !== 2'd0) begin failures++; $display("FAIL reset_occ got=%0d exp=0", occ_o); end
    rst = 1'b0; in_valid_i = 1'b0;
    cycle();
    checks++; if (in_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", in_ready_o); end
  endtask

  task automatic test_streaming();
    out_ready_i = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid_i = 1'b1; in_data_i = DW'(i);
      cycle();
      checks++;
      if (out_valid_o !== 1'b1 || out_data_o !== DW'(i)) begin
        failures++;
        $display("FAIL stream_latency item=%0d got_valid=%0b got=%0h exp=%0h", i, out_valid_o, out_data_o, i);
      end
    end
    in_valid_i = 1'b0;
    cycle();
    checks++; if (occ_o !== 2'd0) begin failures++; $display("FAIL stream_drain_occ got=%0d exp=0", occ_o); end
  endtask

  task automatic test_back_to_back_backpressure();
    logic [DW-1:0] vals[3];
    int j;
    logic acc;
    vals[0] = DW'(8'hA); vals[1] = DW'(8'hB); vals[2] = DW'(8'hC);
    j = 0;
    out_ready_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      in_valid_i = (j < 3);
      if (j < 3) in_data_i = vals[j];
      @(negedge clk);
      acc = in_valid_i && in_ready_o;
      cycle();
      if (acc) j++;
    end
    in_valid_i = (j < 3);
    if (j < 3) in_data_i = vals[j];
    #1;
    checks++; if (occ_o !== 2'(CAP)) begin failures++; $display("FAIL bp_occ got=%0d exp=%0d", occ_o, CAP); end
    checks++; if (in_ready_o !== 1'b0) begin failures++; $display("FAIL bp_ready got=%0b exp=0", in_ready_o); end
    checks++; if (j !== CAP) begin failures++; $display("FAIL bp_accepted got=%0d exp=%0d", j, CAP); end
    checks++; if (out_valid_o !== 1'b1 || out_data_o !== vals[0]) begin failures++; $display("FAIL bp_head got=%0h exp=%0h", out_data_o, vals[0]); end
    out_ready_i = 1'b1;
    for (int c = 0; c < 20 && (j < 3 || occ_o != 2'd0); c++) begin
      in_valid_i = (j < 3);
      if (j < 3) in_data_i = vals[j];
      @(negedge clk);
      acc = in_valid_i && in_ready_o;
      cycle();
      if (acc) j++;
    end
    in_valid_i = 1'b0;
    checks++; if (j !== 3 || occ_o !== 2'd0) begin failures++; $display("FAIL bp_drain got_accepted=%0d got_occ=%0d exp=3/0", j, occ_o); end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL bp_lost got=%0d exp=0", sb.size()); end
  endtask

  task automatic test_stall();
    out_ready_i = 1'b0; in_valid_i = 1'b1; in_data_i = DW'(8'h55);
    cycle();
    in_valid_i = 1'b0; fc_stall_i = 1'b1; out_ready_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid_o !== 1'b0 || in_ready_o !== 1'b0 || out_data_o !== DW'(8'h55) || occ_o !== 2'd1) begin
        failures++;
        $display("FAIL stall_hold cyc=%0d got_v=%0b got_r=%0b got=%0h got_occ=%0d exp=0/0/55/1", c, out_valid_o, in_ready_o, out_data_o, occ_o);
      end
      cycle();
    end
    fc_stall_i = 1'b0;
    @(negedge clk);
    checks++; if (out_valid_o !== 1'b1 || out_data_o !== DW'(8'h55)) begin failures++; $display("FAIL stall_release got_v=%0b got=%0h exp=1/55", out_valid_o, out_data_o); end
    cycle();
    checks++; if (occ_o !== 2'd0) begin failures++; $display("FAIL stall_drain_occ got=%0d exp=0", occ_o); end
  endtask

  task automatic test_flush();
    logic [DW-1:0] vals[2];
    int j;
    logic acc;
    vals[0] = DW'(8'h11); vals[1] = DW'(8'h22);
    j = 0;
    out_ready_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      in_valid_i = (j < CAP);
      if (j < CAP) in_data_i = vals[j];
      @(negedge clk);
      acc = in_valid_i && in_ready_o;
      cycle();
      if (acc) j++;
    end
    checks++; if (occ_o !== 2'(CAP)) begin failures++; $display("FAIL flush_fill_occ got=%0d exp=%0d", occ_o, CAP); end
    fc_flush_i = 1'b1; in_valid_i = 1'b1; in_data_i = DW'(8'h99);
    cycle();
    fc_flush_i = 1'b0; in_valid_i = 1'b0;
    checks++;
    if (occ_o !== 2'd0 || out_data_o !== '0 || out_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL flush_clear got_occ=%0d got=%0h got_v=%0b exp=0/0/0", occ_o, out_data_o, out_valid_o);
    end
    out_ready_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (out_valid_o !== 1'b0) begin failures++; $display("FAIL flush_ghost cyc=%0d got=%0h exp=none", c, out_data_o); end
      cycle();
    end
  endtask

  task automatic test_stall_flush();
    out_ready_i = 1'b0; in_valid_i = 1'b1; in_data_i = DW'(8'h77);
    cycle();
    in_valid_i = 1'b0; fc_stall_i = 1'b1; fc_flush_i = 1'b1;
    cycle();
    cycle();
    fc_stall_i = 1'b0; fc_flush_i = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid_o !== 1'b1 || out_data_o !== DW'(8'h77) || occ_o !== 2'd1) begin
      failures++;
      $display("FAIL stall_flush_kept got_v=%0b got=%0h got_occ=%0d exp=1/77/1", out_valid_o, out_data_o, occ_o);
    end
    out_ready_i = 1'b1;
    cycle();
    checks++; if (sb.size() != 0 || occ_o !== 2'd0) begin failures++; $display("FAIL stall_flush_drain got_sb=%0d got_occ=%0d exp=0/0", sb.size(), occ_o); end
  endtask

  initial begin
    rst = 1'b1; in_valid_i = 1'b0; in_data_i = '0; out_ready_i = 1'b0;
    fc_stall_i = 1'b0; fc_flush_i = 1'b0;
    test_reset();
    test_streaming();
    test_back_to_back_backpressure();
    test_stall();
    test_flush();
    test_stall_flush();
    cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
